switch_hit_decoder: RTL and testbench
=====================================

Name: switch_hit_decoder

Overview:
- Player-input side of the reaction game: the LED path encodes a target as one-hot `led_on`; this block decodes the player's switch action back into a switch index.
- Synchronises and debounces the switch bank, and latches a baseline snapshot on `arm`.
- Detects the first debounced change relative to the baseline and reports it over a valid/ready handshake: which switch toggled, whether it matches the target, or that several toggled at once.
- Sits between the board switches and the game FSM.

Parameters:
- LED_NUM, 18, number of switches/LEDs.
- DEBOUNCE_CYCLES, 50000, clk cycles the synchronised vector must be stable before it is accepted (1 ms at 50 MHz).
- IDX_W, $clog2(LED_NUM), width of index ports.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- switches  input  LED_NUM  raw asynchronous switch levels
- arm  input  1  single-cycle pulse: capture baseline and start watching
- cancel  input  1  single-cycle pulse: abandon watch, return to IDLE
- target_index  input  IDX_W  index of the lit LED; sampled on `arm`
- hit_valid  output  1  report available; held until accepted
- hit_ready  input  1  consumer accepts report when high with `hit_valid`
- hit_index  output  IDX_W  index of the toggled switch (0 when `hit_multi`)
- hit_correct  output  1  single toggle and `hit_index` == captured target
- hit_multi  output  1  more than one switch differed from baseline
- armed  output  1  high in WATCH state

Behaviour:
- Reset (async assert, sync release):
  - sync flops, stable vector, baseline and captured target clear to 0; debounce counter clears to 0.
  - All outputs are 0; state is IDLE.
- Synchroniser: 2-flop per bit, giving `sw_sync`.
- Debounce:
  - One shared counter. Any change of `sw_sync` from its previous-cycle value resets the counter to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES.
  - When count == DEBOUNCE_CYCLES-1, `sw_stable` <= `sw_sync` on the next edge.
  - Raw-to-stable latency: 2 + DEBOUNCE_CYCLES + 1 cycles after the last bounce.
- diff = `sw_stable` ^ baseline. Compute popcount(diff) and a priority encoder giving the lowest set bit.
- States (enum): IDLE, WATCH, REPORT.
  - IDLE:
    - `arm` -> baseline <= `sw_stable`, captured target <= `target_index`, go to WATCH.
    - `cancel` is ignored.
  - WATCH:
    - `cancel` -> IDLE (cancel has priority over a same-cycle detection).
    - `arm` -> re-capture baseline and target, stay in WATCH.
    - diff != 0 -> go to REPORT. Outputs are registered in that same edge:
      - `hit_index` = encoder result if popcount == 1, else 0.
      - `hit_multi` = (popcount > 1).
      - `hit_correct` = (popcount == 1) && (index == captured target).
    - Detection-to-`hit_valid` latency is 1 cycle after `sw_stable` changes.
  - REPORT:
    - `hit_valid` = 1; `hit_index`, `hit_correct` and `hit_multi` are frozen.
    - `hit_valid && hit_ready` -> clear `hit_valid`, `hit_correct` and `hit_multi`, go to IDLE. `hit_index` keeps its value.
    - `arm` and `cancel` are ignored in REPORT; the consumer must accept the report first.
- Target index >= LED_NUM is never matched, so `hit_correct` stays 0.
- A switch toggled and returned before debounce completes produces no report.
- Reset asserted mid-REPORT drops the report immediately; no handshake is required.
- `armed` = (state == WATCH).

Decomposition:
- Package `reaction_pkg`:
  - `hit_state_t` enum {IDLE, WATCH, REPORT}.
  - LED_NUM default constant.
  - Function `lowest_set_index`.
  - Function `popcount_gt1`.
- Sub-module `switch_debouncer`: parameters W and DEBOUNCE_CYCLES. It contains the sync flops, the shared counter and `sw_stable`.
- `switch_hit_decoder` instantiates `switch_debouncer` and holds the FSM plus the report registers.

Test Plan (LED_NUM=18, DEBOUNCE_CYCLES=4):
- Reset, then drive switches=0 for 10 cycles, `arm` with target=5, then set switches[5]=1 -> `hit_valid` rises 8 cycles after the switch edge, with `hit_index`=5, `hit_correct`=1, `hit_multi`=0. `hit_ready`=1 -> `hit_valid` drops the next cycle and state returns to IDLE.
- Same as above with target=5, but toggle switches[12] -> `hit_index`=12, `hit_correct`=0. Hold `hit_ready`=0 for 20 cycles -> `hit_valid` and the report fields stay constant.
- Baseline 18'h00003, `arm` target=0, then switches go to 18'h0000C in one step -> `hit_multi`=1, `hit_index`=0, `hit_correct`=0.
- Bounce switches[3] 1/0 every 2 cycles for 20 cycles, ending at 0 -> no `hit_valid`. Then hold it at 1 -> a single report with `hit_index`=3.
- In WATCH, assert `cancel` in the cycle `sw_stable` changes -> IDLE, no `hit_valid`, `armed`=0. Then assert `reset` while in REPORT -> all outputs are 0 immediately, without waiting for a clock edge.
- With `arm` target=17, toggle switches[17] -> `hit_correct`=1. Then `arm` target=18 (out of range), toggle switches[0] -> `hit_correct`=0, `hit_index`=0.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and helpers for the reaction-game switch decoding path.
// Latency: n/a (types and pure combinational functions only).
// Backpressure: n/a.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WATCH  = 2'd1,
        REPORT = 2'd2
    } hit_state_t;

    localparam int LED_NUM_DEFAULT = 18;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int lowest_set_index(input logic [63:0] v);
        int idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit leaves something.
    function automatic logic popcount_gt1(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Synchronises a switch bank and only passes a vector that has held still long enough.
// Latency: 2 sync + DEBOUNCE_CYCLES + 1 cycles from the last raw change to sw_stable.
// Backpressure: none; free-running, any change restarts the shared stability counter.
module switch_debouncer #(
    parameter int W               = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] switches,
    output logic [W-1:0] sw_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_AT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     sync1;
    logic [W-1:0]     sw_sync;
    logic [W-1:0]     sw_prev;
    logic [CNT_W-1:0] count;

    // Two-flop synchroniser, change detector, saturating counter and stable-vector load.
    // The load is gated on "no change this cycle" so a flip landing on the
    // terminal count is never accepted unfiltered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sw_sync   <= '0;
            sw_prev   <= '0;
            count     <= '0;
            sw_stable <= '0;
        end else begin
            sync1   <= switches;
            sw_sync <= sync1;
            sw_prev <= sw_sync;
            if (sw_sync != sw_prev) begin
                count <= '0;
            end else if (count != CNT_MAX) begin
                count <= count + 1'b1;
            end
            if ((sw_sync == sw_prev) && (count == LOAD_AT)) begin
                sw_stable <= sw_sync;
            end
        end
    end

endmodule

// File: rtl/switch_hit_decoder.sv
// Decodes the first debounced switch toggle after arm into an index/correct/multi report.
// Latency: report valid 1 cycle after the debounced vector departs from the baseline.
// Backpressure: report held frozen in REPORT until hit_ready; arm/cancel ignored meanwhile.
module switch_hit_decoder
    import reaction_pkg::*;
#(
    parameter int LED_NUM         = LED_NUM_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int IDX_W           = $clog2(LED_NUM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LED_NUM-1:0] switches,
    input  logic               arm,
    input  logic               cancel,
    input  logic [IDX_W-1:0]   target_index,
    output logic               hit_valid,
    input  logic               hit_ready,
    output logic [IDX_W-1:0]   hit_index,
    output logic               hit_correct,
    output logic               hit_multi,
    output logic               armed
);

    logic [LED_NUM-1:0] sw_stable;
    logic [LED_NUM-1:0] diff;
    logic [63:0]        diff_ext;
    logic [IDX_W-1:0]   enc_idx;
    logic               multi;

    hit_state_t         state_q, state_d;
    logic [LED_NUM-1:0] baseline_q, baseline_d;
    logic [IDX_W-1:0]   target_q, target_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               corr_q, corr_d;
    logic               multi_q, multi_d;

    switch_debouncer #(
        .W               (LED_NUM),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .reset     (reset),
        .switches  (switches),
        .sw_stable (sw_stable)
    );

    assign diff     = sw_stable ^ baseline_q;
    assign diff_ext = 64'(diff);
    assign enc_idx  = IDX_W'(lowest_set_index(diff_ext));
    assign multi    = popcount_gt1(diff_ext);

    // Next-state and report-register logic; cancel beats arm, arm beats detection.
    always_comb begin
        state_d    = state_q;
        baseline_d = baseline_q;
        target_d   = target_q;
        idx_d      = idx_q;
        corr_d     = corr_q;
        multi_d    = multi_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    baseline_d = sw_stable;
                    target_d   = target_index;
                    state_d    = WATCH;
                end
            end
            WATCH: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (arm) begin
                    baseline_d = sw_stable;
                    target_d   = target_index;
                end else if (diff != '0) begin
                    state_d = REPORT;
                    idx_d   = multi ? '0 : enc_idx;
                    multi_d = multi;
                    // Out-of-range targets can never equal an encoder result.
                    corr_d  = !multi && (enc_idx == target_q);
                end
            end
            REPORT: begin
                if (hit_ready) begin
                    state_d = IDLE;
                    corr_d  = 1'b0;
                    multi_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and report registers; reset drops any pending report at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baseline_q <= '0;
            target_q   <= '0;
            idx_q      <= '0;
            corr_q     <= 1'b0;
            multi_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            baseline_q <= baseline_d;
            target_q   <= target_d;
            idx_q      <= idx_d;
            corr_q     <= corr_d;
            multi_q    <= multi_d;
        end
    end

    assign hit_valid   = (state_q == REPORT);
    assign armed       = (state_q == WATCH);
    assign hit_index   = idx_q;
    assign hit_correct = corr_q;
    assign hit_multi   = multi_q;

endmodule

// File: tb/tb_switch_hit_decoder.sv
// Directed bench for switch_hit_decoder with a short debounce window.
// Latency: expects reports 8 cycles after a clean switch edge (2 sync + 4 + 1 + 1).
// Backpressure: exercises held reports, cancel races and reset during REPORT.
module tb_switch_hit_decoder;

    localparam int LED_NUM = 18;
    localparam int DEB     = 4;
    localparam int IDX_W   = 5;
    localparam int EXP_LAT = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [LED_NUM-1:0] switches;
    logic               arm;
    logic               cancel;
    logic [IDX_W-1:0]   target_index;
    logic               hit_valid;
    logic               hit_ready;
    logic [IDX_W-1:0]   hit_index;
    logic               hit_correct;
    logic               hit_multi;
    logic               armed;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [LED_NUM-1:0] base;
        logic [LED_NUM-1:0] sw;
        logic [IDX_W-1:0]   tgt;
        logic [IDX_W-1:0]   e_idx;
        logic               e_corr;
        logic               e_multi;
        int                 hold;
    } vec_t;

    vec_t vecs [6];

    switch_hit_decoder #(
        .LED_NUM         (LED_NUM),
        .DEBOUNCE_CYCLES (DEB),
        .IDX_W           (IDX_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .switches     (switches),
        .arm          (arm),
        .cancel       (cancel),
        .target_index (target_index),
        .hit_valid    (hit_valid),
        .hit_ready    (hit_ready),
        .hit_index    (hit_index),
        .hit_correct  (hit_correct),
        .hit_multi    (hit_multi),
        .armed        (armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int maxc, output int lat);
        lat = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clk);
            #1;
            if (hit_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pulse_arm(input logic [IDX_W-1:0] tgt);
        target_index = tgt;
        arm          = 1'b1;
        tick(1);
        arm          = 1'b0;
        target_index = '0;
    endtask

    task automatic accept(input string tag, input logic [IDX_W-1:0] e_idx);
        hit_ready = 1'b1;
        tick(1);
        hit_ready = 1'b0;
        check({tag, "_acc_valid"}, hit_valid, 0);
        check({tag, "_acc_corr"}, hit_correct, 0);
        check({tag, "_acc_multi"}, hit_multi, 0);
        check({tag, "_acc_idx_kept"}, hit_index, e_idx);
        check({tag, "_acc_armed"}, armed, 0);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int    lat;
        logic  ok;
        string tag;
        tag = $sformatf("v%0d", n);
        switches = v.base;
        tick(10);
        check({tag, "_idle_valid"}, hit_valid, 0);
        pulse_arm(v.tgt);
        check({tag, "_armed"}, armed, 1);
        switches = v.sw;
        wait_valid(20, lat);
        check({tag, "_latency"}, lat, EXP_LAT);
        check({tag, "_idx"}, hit_index, v.e_idx);
        check({tag, "_corr"}, hit_correct, v.e_corr);
        check({tag, "_multi"}, hit_multi, v.e_multi);
        check({tag, "_armed_in_report"}, armed, 0);
        if (v.hold > 0) begin
            ok = 1'b1;
            for (int i = 0; i < v.hold; i++) begin
                tick(1);
                if (!(hit_valid === 1'b1 && hit_index === v.e_idx &&
                      hit_correct === v.e_corr && hit_multi === v.e_multi)) ok = 1'b0;
            end
            check({tag, "_hold_stable"}, ok, 1);
        end
        accept(tag, v.e_idx);
    endtask

    initial begin
        int   lat;
        logic seen;

        vecs[0] = '{base: 18'h00000, sw: 18'h00020, tgt: 5'd5,  e_idx: 5'd5,  e_corr: 1'b1, e_multi: 1'b0, hold: 0};
        vecs[1] = '{base: 18'h00000, sw: 18'h01000, tgt: 5'd5,  e_idx: 5'd12, e_corr: 1'b0, e_multi: 1'b0, hold: 20};
        vecs[2] = '{base: 18'h00003, sw: 18'h0000C, tgt: 5'd0,  e_idx: 5'd0,  e_corr: 1'b0, e_multi: 1'b1, hold: 0};
        vecs[3] = '{base: 18'h00000, sw: 18'h20000, tgt: 5'd17, e_idx: 5'd17, e_corr: 1'b1, e_multi: 1'b0, hold: 0};
        vecs[4] = '{base: 18'h00000, sw: 18'h00001, tgt: 5'd18, e_idx: 5'd0,  e_corr: 1'b0, e_multi: 1'b0, hold: 0};
        vecs[5] = '{base: 18'h00020, sw: 18'h00000, tgt: 5'd5,  e_idx: 5'd5,  e_corr: 1'b1, e_multi: 1'b0, hold: 0};

        reset        = 1'b1;
        switches     = '0;
        arm          = 1'b0;
        cancel       = 1'b0;
        hit_ready    = 1'b0;
        target_index = '0;
        tick(3);
        check("rst_valid", hit_valid, 0);
        check("rst_idx", hit_index, 0);
        check("rst_corr", hit_correct, 0);
        check("rst_multi", hit_multi, 0);
        check("rst_armed", armed, 0);
        reset = 1'b0;
        tick(10);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Bounce bit 3 faster than the debounce window, ending low: no report.
        switches = '0;
        tick(10);
        pulse_arm(5'd3);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            switches[3] = ~switches[3];
            for (int c = 0; c < 2; c++) begin
                tick(1);
                seen |= hit_valid;
            end
        end
        for (int c = 0; c < 15; c++) begin
            tick(1);
            seen |= hit_valid;
        end
        check("bounce_no_report", seen, 0);
        check("bounce_still_armed", armed, 1);
        switches[3] = 1'b1;
        wait_valid(20, lat);
        check("bounce_latency", lat, EXP_LAT);
        check("bounce_idx", hit_index, 3);
        check("bounce_corr", hit_correct, 1);
        accept("bounce", 5'd3);

        // Cancel landing in the same cycle the debounced vector changes.
        switches = '0;
        tick(10);
        pulse_arm(5'd7);
        switches = 18'h00080;
        tick(EXP_LAT - 1);
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
        check("cancel_valid", hit_valid, 0);
        check("cancel_armed", armed, 0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            seen |= hit_valid;
        end
        check("cancel_no_report", seen, 0);

        // Fresh report, then reset mid-REPORT clears outputs without a clock edge.
        pulse_arm(5'd9);
        switches = 18'h00280;
        wait_valid(20, lat);
        check("prerst_latency", lat, EXP_LAT);
        check("prerst_idx", hit_index, 9);
        check("prerst_corr", hit_correct, 1);
        #2;
        reset = 1'b1;
        #1;
        check("asyncrst_valid", hit_valid, 0);
        check("asyncrst_idx", hit_index, 0);
        check("asyncrst_corr", hit_correct, 0);
        check("asyncrst_multi", hit_multi, 0);
        check("asyncrst_armed", armed, 0);
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
